// File: rtl/disparity_pkg.sv
// Shared definitions for the disparity selection block.
// Holds the default cost width, default disparity count and the state
// encoding of the select FSM. No ports (package only).
package disparity_pkg;

  localparam int COST_W_DEF   = 6;
  localparam int NUM_DISP_DEF = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/disparity_min_cmp.sv
// Combinational compare-and-update step of the running minimum search.
// Ports:
//   cur_cost / cur_disp : stored running minimum and its disparity index
//   new_cost / new_disp : incoming cost and its disparity index
//   nxt_cost / nxt_disp : updated minimum; the new value wins only when it
//                         is strictly smaller, so ties keep the lower index
module disparity_min_cmp #(
  parameter int COST_W = 6,
  parameter int DISP_W = 4
) (
  input  logic [COST_W-1:0] cur_cost,
  input  logic [DISP_W-1:0] cur_disp,
  input  logic [COST_W-1:0] new_cost,
  input  logic [DISP_W-1:0] new_disp,
  output logic [COST_W-1:0] nxt_cost,
  output logic [DISP_W-1:0] nxt_disp
);

  logic take_new;

  assign take_new = (new_cost < cur_cost);
  assign nxt_cost = take_new ? new_cost : cur_cost;
  assign nxt_disp = take_new ? new_disp : cur_disp;

endmodule

// File: rtl/disparity_select.sv
// Winner-take-all disparity selection: consumes NUM_DISP Hamming costs per
// pixel (disparity 0 first) and presents the index and value of the lowest
// cost; on ties the lowest disparity wins.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active low
//   in_valid  : in_cost carries a cost this cycle
//   in_ready  : block accepts in_cost this cycle (high in ACCUM only)
//   in_cost   : cost for the next disparity
//   out_valid : result is held (HOLD state)
//   out_ready : consumer takes the result
//   out_disp  : disparity index of the minimum cost
//   out_cost  : minimum cost value
//   out_conf  : second-lowest cost minus minimum (only with
//               DISPARITY_SELECT_CONF_EN defined)
//
// Handshake: a beat moves on a rising clk edge exactly when valid and ready
// are both high on that edge; valid never depends on ready, and in_ready is
// a pure function of the registered state (no path from out_ready).
//
// Optional feature macro: DISPARITY_SELECT_CONF_EN adds out_conf and the
// second-minimum tracker.
module disparity_select
  import disparity_pkg::*;
#(
  parameter int COST_W   = COST_W_DEF,
  parameter int NUM_DISP = NUM_DISP_DEF,
  parameter int DISP_W   = $clog2(NUM_DISP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COST_W-1:0] in_cost,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DISP_W-1:0] out_disp,
  output logic [COST_W-1:0] out_cost
`ifdef DISPARITY_SELECT_CONF_EN
  ,
  output logic [COST_W-1:0] out_conf
`endif
);

  localparam logic [DISP_W-1:0] LAST_DISP = DISP_W'(NUM_DISP - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DISP_W-1:0] cnt;
  logic [COST_W-1:0] min_cost;
  logic [DISP_W-1:0] min_disp;
  logic [COST_W-1:0] cmp_cost;
  logic [DISP_W-1:0] cmp_disp;
  logic              accept;
  logic              first_beat;
  logic              last_beat;

  // Derived from state directly so in_ready never feeds back into itself.
  assign accept     = in_valid && (state == ACCUM);
  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == LAST_DISP);

  disparity_min_cmp #(
    .COST_W(COST_W),
    .DISP_W(DISP_W)
  ) u_min_cmp (
    .cur_cost(min_cost),
    .cur_disp(min_disp),
    .new_cost(in_cost),
    .new_disp(cnt),
    .nxt_cost(cmp_cost),
    .nxt_disp(cmp_disp)
  );

  // FSM next state and outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && last_beat) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Disparity counter and running minimum. The running minimum doubles as
  // the result register: it is frozen in HOLD because no beats are accepted
  // there, and the first beat of the next pixel overwrites it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      min_cost <= '0;
      min_disp <= '0;
    end else if (accept) begin
      cnt <= last_beat ? '0 : cnt + DISP_W'(1);
      if (first_beat) begin
        min_cost <= in_cost;
        min_disp <= '0;
      end else begin
        min_cost <= cmp_cost;
        min_disp <= cmp_disp;
      end
    end
  end

  assign out_disp = min_disp;
  assign out_cost = min_cost;

`ifdef DISPARITY_SELECT_CONF_EN
  // Second-lowest cost, ties counted: an equal cost to the minimum becomes
  // the second minimum, giving a confidence of 0.
  logic [COST_W-1:0] sec_cost;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_cost <= '0;
    end else if (accept) begin
      if (first_beat) begin
        sec_cost <= '1;
      end else if (in_cost < min_cost) begin
        sec_cost <= min_cost;
      end else if (in_cost < sec_cost) begin
        sec_cost <= in_cost;
      end
    end
  end

  assign out_conf = sec_cost - min_cost;
`endif

endmodule

// File: tb/tb_disparity_select.sv
// Self-checking bench for disparity_select with NUM_DISP=4, COST_W=6.
module tb_disparity_select;

  localparam int COST_W   = 6;
  localparam int NUM_DISP = 4;
  localparam int DISP_W   = 2;

  typedef logic [COST_W-1:0] cost_arr_t [NUM_DISP];
  typedef int gap_arr_t [NUM_DISP];

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [COST_W-1:0] in_cost;
  logic              out_valid;
  logic              out_ready;
  logic [DISP_W-1:0] out_disp;
  logic [COST_W-1:0] out_cost;
`ifdef DISPARITY_SELECT_CONF_EN
  logic [COST_W-1:0] out_conf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int accept_cyc;
  // expected {disp, cost, conf}
  logic [DISP_W+2*COST_W-1:0] exp_q[$];

  disparity_select #(
    .COST_W(COST_W),
    .NUM_DISP(NUM_DISP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_cost(in_cost),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_disp(out_disp),
    .out_cost(out_cost)
`ifdef DISPARITY_SELECT_CONF_EN
    ,
    .out_conf(out_conf)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Minimum = first occurrence of the smallest value; confidence = the
  // second element of the cost list in sorted order minus the smallest.
  function automatic logic [DISP_W+2*COST_W-1:0] ref_model(input cost_arr_t c);
    int mi;
    int mn;
    int n_min;
    int second;
    mn = 1000;
    mi = 0;
    for (int i = 0; i < NUM_DISP; i++) if (int'(c[i]) < mn) begin mn = int'(c[i]); mi = i; end
    n_min = 0;
    second = 1000;
    for (int i = 0; i < NUM_DISP; i++) begin
      if (int'(c[i]) == mn) n_min++;
      else if (int'(c[i]) < second) second = int'(c[i]);
    end
    if (n_min > 1) second = mn;
    return {DISP_W'(mi), COST_W'(mn), COST_W'(second - mn)};
  endfunction

  // ---------------- driver ----------------
  // Returns #1 after the edge that accepted the last beat.
  task automatic send_pixel(input cost_arr_t c, input gap_arr_t g);
    int n;
    for (int i = 0; i < NUM_DISP; i++) begin
      in_valid = 1'b0;
      repeat (g[i]) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_cost  = c[i];
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL ready_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
      end
      if (i == 0) accept_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_cost = '0; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_disp !== '0) begin errors++; $display("FAIL rst_out_disp: got %0d want 0", out_disp); end
    checks++; if (out_cost !== '0) begin errors++; $display("FAIL rst_out_cost: got %0d want 0", out_cost); end
`ifdef DISPARITY_SELECT_CONF_EN
    checks++; if (out_conf !== '0) begin errors++; $display("FAIL rst_out_conf: got %0d want 0", out_conf); end
`endif
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send_pixel('{6'd9, 6'd3, 6'd7, 6'd5}, '{0, 0, 0, 0});
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    checks++; if (out_disp !== 2'd1) begin errors++; $display("FAIL basic_disp: got %0d want 1", out_disp); end
    checks++; if (out_cost !== 6'd3) begin errors++; $display("FAIL basic_cost: got %0d want 3", out_cost); end
`ifdef DISPARITY_SELECT_CONF_EN
    checks++; if (out_conf !== 6'd2) begin errors++; $display("FAIL basic_conf: got %0d want 2", out_conf); end
`endif
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release: out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ties();
    send_pixel('{6'd4, 6'd2, 6'd2, 6'd6}, '{0, 0, 0, 0});
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ties_valid: got %0b want 1", out_valid); end
    checks++; if (out_disp !== 2'd1) begin errors++; $display("FAIL ties_disp: got %0d want 1", out_disp); end
    checks++; if (out_cost !== 6'd2) begin errors++; $display("FAIL ties_cost: got %0d want 2", out_cost); end
`ifdef DISPARITY_SELECT_CONF_EN
    checks++; if (out_conf !== 6'd0) begin errors++; $display("FAIL ties_conf: got %0d want 0", out_conf); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int hs;
    out_ready = 1'b0;
    send_pixel('{6'd20, 6'd11, 6'd30, 6'd11}, '{0, 0, 0, 0});
    for (int k = 0; k < 5; k++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_disp !== 2'd1 || out_cost !== 6'd11) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%0b disp=%0d cost=%0d want 1 1 11", k, out_valid, out_disp, out_cost);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_cost   = 6'd7;
    hs = cyc;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_return: out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
    send_pixel('{6'd7, 6'd6, 6'd5, 6'd4}, '{0, 0, 0, 0});
    checks++; if (accept_cyc - hs !== 1) begin
      errors++; $display("FAIL bp_next_accept: got %0d cycles after handshake want 1", accept_cyc - hs);
    end
    checks++; if (out_valid !== 1'b1 || out_disp !== 2'd3 || out_cost !== 6'd4) begin
      errors++; $display("FAIL bp_next_result: valid=%0b disp=%0d cost=%0d want 1 3 4", out_valid, out_disp, out_cost);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    send_pixel('{6'd8, 6'd1, 6'd8, 6'd8}, '{0, 2, 1, 0});
    checks++; if (out_valid !== 1'b1 || out_disp !== 2'd1 || out_cost !== 6'd1) begin
      errors++; $display("FAIL gaps_result: valid=%0b disp=%0d cost=%0d want 1 1 1", out_valid, out_disp, out_cost);
    end
`ifdef DISPARITY_SELECT_CONF_EN
    checks++; if (out_conf !== 6'd7) begin errors++; $display("FAIL gaps_conf: got %0d want 7", out_conf); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    cost_arr_t c;
    c = '{6'd5, 6'd6, 6'd0, 6'd7};
    // two beats of a pixel that gets discarded
    in_valid = 1'b1; in_cost = 6'd1; @(posedge clk); #1;
    in_cost = 6'd2; @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0; #2;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cost !== '0 || out_disp !== '0) begin
      errors++; $display("FAIL midrst_state: valid=%0b ready=%0b cost=%0d disp=%0d want 0 1 0 0", out_valid, in_ready, out_cost, out_disp);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NUM_DISP - 1; i++) begin
      in_valid = 1'b1; in_cost = c[i];
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d]: out_valid=%0b want 0", i, out_valid); end
    end
    in_cost = c[NUM_DISP-1];
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_disp !== 2'd2 || out_cost !== 6'd0) begin
      errors++; $display("FAIL midrst_result: valid=%0b disp=%0d cost=%0d want 1 2 0", out_valid, out_disp, out_cost);
    end
    @(posedge clk); #1;
    // reset while holding a result
    out_ready = 1'b0;
    send_pixel('{6'd9, 6'd9, 6'd1, 6'd9}, '{0, 0, 0, 0});
    rst = 1'b0; #2;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL holdrst_state: valid=%0b ready=%0b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    send_pixel('{6'd3, 6'd3, 6'd3, 6'd3}, '{0, 0, 0, 0});
    checks++; if (out_valid !== 1'b1 || out_disp !== 2'd0 || out_cost !== 6'd3) begin
      errors++; $display("FAIL holdrst_result: valid=%0b disp=%0d cost=%0d want 1 0 3", out_valid, out_disp, out_cost);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    send_pixel('{6'd63, 6'd63, 6'd63, 6'd63}, '{0, 1, 0, 0});
    checks++; if (out_valid !== 1'b1 || out_disp !== 2'd0 || out_cost !== 6'd63) begin
      errors++; $display("FAIL ones_result: valid=%0b disp=%0d cost=%0d want 1 0 63", out_valid, out_disp, out_cost);
    end
`ifdef DISPARITY_SELECT_CONF_EN
    checks++; if (out_conf !== 6'd0) begin errors++; $display("FAIL ones_conf: got %0d want 0", out_conf); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    cost_arr_t c;
    logic [DISP_W+2*COST_W-1:0] e;
    int first [3];
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NUM_DISP; i++) c[i] = COST_W'($urandom_range(63));
      exp_q.push_back(ref_model(c));
      send_pixel(c, '{0, 0, 0, 0});
      first[p] = accept_cyc;
      e = exp_q.pop_front();
      checks++; if ({out_valid, out_disp, out_cost} !== {1'b1, e[DISP_W+2*COST_W-1:COST_W]}) begin
        errors++; $display("FAIL b2b_result[%0d]: valid=%0b disp=%0d cost=%0d want 1 %0d %0d", p, out_valid, out_disp, out_cost,
                           e[DISP_W+2*COST_W-1:2*COST_W], e[2*COST_W-1:COST_W]);
      end
    end
    @(posedge clk); #1;
    checks++; if (first[2] - first[0] !== 2 * (NUM_DISP + 1)) begin
      errors++; $display("FAIL b2b_rate: %0d cycles for 2 pixels want %0d", first[2] - first[0], 2 * (NUM_DISP + 1));
    end
  endtask

  task automatic test_random();
    cost_arr_t c;
    gap_arr_t g;
    logic [DISP_W+2*COST_W-1:0] e;
    int hold;
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < NUM_DISP; i++) begin
        c[i] = (p % 2 == 0) ? COST_W'($urandom_range(63)) : COST_W'($urandom_range(63, 60));
        g[i] = $urandom_range(2);
      end
      hold = $urandom_range(3);
      out_ready = (hold == 0);
      exp_q.push_back(ref_model(c));
      send_pixel(c, g);
      e = exp_q.pop_front();
      for (int k = 0; k <= hold; k++) begin
        if (k == hold) out_ready = 1'b1;
        checks++; if ({out_valid, out_disp, out_cost} !== {1'b1, e[DISP_W+2*COST_W-1:COST_W]}) begin
          errors++; $display("FAIL rand_result[%0d.%0d]: valid=%0b disp=%0d cost=%0d want 1 %0d %0d", p, k, out_valid, out_disp,
                             out_cost, e[DISP_W+2*COST_W-1:2*COST_W], e[2*COST_W-1:COST_W]);
        end
`ifdef DISPARITY_SELECT_CONF_EN
        checks++; if (out_conf !== e[COST_W-1:0]) begin
          errors++; $display("FAIL rand_conf[%0d.%0d]: got %0d want %0d", p, k, out_conf, e[COST_W-1:0]);
        end
`endif
        @(posedge clk); #1;
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_queue: %0d left want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_all_ones();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disparity_select.md
DISPARITY_SELECT -- requirements
Module: disparity_select

Interface
REQ-001 The block SHALL have parameter COST_W, default 6, giving the width of one Hamming cost (popcount of a 32-bit census XOR).
REQ-002 The block SHALL have parameter NUM_DISP, default 16, giving the number of disparities per pixel (minimum 2).
REQ-003 The block SHALL have parameter DISP_W, default $clog2(NUM_DISP), giving the width of a disparity index.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_cost is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_cost this cycle.
REQ-008 The block SHALL have port in_cost, input, COST_W bits: cost for the next disparity, in ascending order 0..NUM_DISP-1.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is held.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port out_disp, output, DISP_W bits: index of the minimum cost.
REQ-012 The block SHALL have port out_cost, output, COST_W bits: the minimum cost value.

Function
REQ-013 An input beat SHALL be accepted iff in_valid and in_ready are both high on a rising clk.
REQ-014 The block SHALL have states ACCUM and HOLD; in_ready=1 in ACCUM and 0 in HOLD; out_valid=1 only in HOLD.
REQ-015 In ACCUM, an internal disparity counter SHALL increment on each accepted beat from 0 to NUM_DISP-1.
REQ-016 On an accepted beat with counter=0, the running minimum SHALL be loaded unconditionally with (in_cost, 0).
REQ-017 On an accepted beat with counter>0, the running minimum SHALL update only if in_cost is strictly less than the stored cost, so ties keep the lowest disparity.
REQ-018 On accepting the beat with counter=NUM_DISP-1, the block SHALL register the final result, including that beat, enter HOLD and reset the counter to 0.
REQ-019 Latency SHALL be out_valid high on the cycle after the last beat is accepted.
REQ-020 In HOLD, out_disp and out_cost SHALL stay stable until out_valid and out_ready are both high; the block SHALL then return to ACCUM on the next cycle.
REQ-021 Sustained throughput SHALL be one pixel per NUM_DISP+1 cycles, with no combinational path from out_ready to in_ready.
REQ-022 Gaps (in_valid low) SHALL leave the counter and running minimum unchanged.
REQ-023 A cost of all-ones SHALL be a legal value; if every cost is all-ones, the result SHALL be (disp 0, all-ones).

Reset
REQ-024 While rst is low, the state SHALL be ACCUM, the counter 0, out_valid 0, in_ready 1, out_disp 0, out_cost 0 and the running minimum 0.
REQ-025 Reset asserted mid-pixel or in HOLD SHALL discard the partial or pending result; the first beat after release SHALL be treated as disparity 0.

Configuration
REQ-026 With macro DISPARITY_SELECT_CONF_EN defined, the block SHALL add output out_conf (COST_W bits) equal to the second-lowest cost minus the minimum, counting ties, so a duplicated minimum gives 0, and SHALL track the second minimum, reset value 0, stable in HOLD.
REQ-027 Without DISPARITY_SELECT_CONF_EN, the block SHALL have no out_conf port and no second-minimum logic.

Structure
REQ-028 The default COST_W and NUM_DISP and the state encoding (ACCUM=0, HOLD=1) SHALL live in the shared package disparity_pkg.
REQ-029 The compare-and-update step SHALL be one sub-module, disparity_min_cmp (combinational: current min/index and new cost/index in, next min/index out, strict less-than).

Verification
REQ-030 With NUM_DISP=4, costs 9,3,7,5 back-to-back and out_ready=1, the bench SHALL see out_valid on the next cycle with out_disp=1 and out_cost=3.
REQ-031 With ties, costs 4,2,2,6, the bench SHALL see out_disp=1 and out_cost=2, and out_conf=0 when CONF_EN is defined.
REQ-032 With out_ready held low for 5 cycles after the result, the bench SHALL see in_ready=0, the outputs unchanged throughout, and the next pixel accepted one cycle after the handshake.
REQ-033 With in_valid gaps between costs 8,_,_,1,_,8,8, the bench SHALL see out_disp=1 and out_cost=1.
REQ-034 With rst asserted after 2 of 4 beats, then costs 5,6,0,7, the bench SHALL see out_disp=2 and out_cost=0, with no stale result emitted.
REQ-035 With all costs 63 at COST_W=6, the bench SHALL see out_disp=0 and out_cost=63.
